// File: rtl/dualram_ctrl_if.sv
// Bus bundle between the two requesters (CPU data bus = port 1, JPEG/DMA = port 2) and dualram_ctrl.
// Ports: address/wdata/enw/enr per port in; rdata per port, ready, coll, unmapped[1:0], ctrl_out, clear_done out.
// Optional macro DUALRAM_BYTEWR_EN adds per-port byte strobes wstrb1/wstrb2 (WIDTH/8 bits).
interface dualram_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int NCTRL = 2
);
    logic [WIDTH-1:0]       address1;
    logic [WIDTH-1:0]       address2;
    logic [WIDTH-1:0]       wdata1;
    logic [WIDTH-1:0]       wdata2;
    logic                   enw1;
    logic                   enw2;
    logic                   enr1;
    logic                   enr2;
`ifdef DUALRAM_BYTEWR_EN
    logic [WIDTH/8-1:0]     wstrb1;
    logic [WIDTH/8-1:0]     wstrb2;
`endif
    logic [WIDTH-1:0]       rdata1;
    logic [WIDTH-1:0]       rdata2;
    logic                   ready;
    logic                   coll;
    logic [1:0]             unmapped;
    logic [NCTRL*WIDTH-1:0] ctrl_out;
    logic                   clear_done;

`ifdef DUALRAM_BYTEWR_EN
    modport master (
        output address1, address2, wdata1, wdata2, enw1, enw2, enr1, enr2, wstrb1, wstrb2,
        input  rdata1, rdata2, ready, coll, unmapped, ctrl_out, clear_done
    );
    modport slave (
        input  address1, address2, wdata1, wdata2, enw1, enw2, enr1, enr2, wstrb1, wstrb2,
        output rdata1, rdata2, ready, coll, unmapped, ctrl_out, clear_done
    );
`else
    modport master (
        output address1, address2, wdata1, wdata2, enw1, enw2, enr1, enr2,
        input  rdata1, rdata2, ready, coll, unmapped, ctrl_out, clear_done
    );
    modport slave (
        input  address1, address2, wdata1, wdata2, enw1, enw2, enr1, enr2,
        output rdata1, rdata2, ready, coll, unmapped, ctrl_out, clear_done
    );
`endif
endinterface

// File: rtl/dualram_ctrl.sv
// Dual-port data RAM with control-register window, unmapped detect, port-1-wins collisions and a clear engine.
// Latency: registered reads, data one cycle after an accepted enr; writes land on the accepting edge.
// Backpressure: ready drops for DEPTH cycles while clearing; requesters hold their request until ready=1.
// Ports: clk, rst (sync, active-high), bus (dualram_ctrl_if.slave: per-port address/wdata/enw/enr in,
//        rdata1/2, ready, coll, unmapped[1:0], ctrl_out, clear_done out).
// Optional macro DUALRAM_BYTEWR_EN: byte strobes on both ports, honoured by RAM and control writes.
module dualram_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1200,
    parameter int BASE      = 206800,
    parameter int CTRL_ADDR = 411698,
    parameter int NCTRL     = 2
) (
    input  logic         clk,
    input  logic         rst,
    dualram_ctrl_if.slave bus
);
    localparam int CW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CIW = (NCTRL > 1) ? $clog2(NCTRL) : 1;
    localparam logic [WIDTH-1:0] BASE_W  = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] CTRL_W  = WIDTH'(CTRL_ADDR);
    localparam logic [WIDTH-1:0] NCTRL_W = WIDTH'(NCTRL);
    localparam logic [CW-1:0]    LAST    = CW'(DEPTH - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_ctrl [NCTRL];
    logic [WIDTH-1:0] w_ctrl_nxt [NCTRL];
    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rdata1, r_rdata2;
    logic             r_coll, r_done;
    logic [1:0]       r_unmapped;

    logic             w_ready, w_clr_busy, w_clr_last, w_clr_start;
    logic             w_ram1, w_ram2, w_ctl1, w_ctl2;
    logic [CW-1:0]    w_idx1, w_idx2;
    logic [CIW-1:0]   w_cidx1, w_cidx2;
    logic             w_same, w_overlap, w_coll, w_merge;
    logic             w_wr_ram1, w_wr_ram2, w_wr_ctl1, w_wr_ctl2;
    logic [WIDTH-1:0] w_mask1, w_mask2, w_mem_p1, w_mem_p2, w_p1_base;

    // Decode: test the lower bound first so the subtraction can never wrap.
    assign w_ram1  = (bus.address1 >= BASE_W) && ((bus.address1 - BASE_W) < DEPTH_W);
    assign w_ram2  = (bus.address2 >= BASE_W) && ((bus.address2 - BASE_W) < DEPTH_W);
    assign w_ctl1  = (bus.address1 >= CTRL_W) && ((bus.address1 - CTRL_W) < NCTRL_W);
    assign w_ctl2  = (bus.address2 >= CTRL_W) && ((bus.address2 - CTRL_W) < NCTRL_W);
    assign w_idx1  = CW'(bus.address1 - BASE_W);
    assign w_idx2  = CW'(bus.address2 - BASE_W);
    assign w_cidx1 = CIW'(bus.address1 - CTRL_W);
    assign w_cidx2 = CIW'(bus.address2 - CTRL_W);

`ifdef DUALRAM_BYTEWR_EN
    always_comb begin
        w_mask1 = '0;
        w_mask2 = '0;
        for (int b = 0; b < WIDTH/8; b++) begin
            w_mask1[b*8 +: 8] = {8{bus.wstrb1[b]}};
            w_mask2[b*8 +: 8] = {8{bus.wstrb2[b]}};
        end
    end
    // Disjoint strobes on the same word are merged rather than dropped.
    assign w_overlap = |(bus.wstrb1 & bus.wstrb2);
`else
    assign w_mask1   = '1;
    assign w_mask2   = '1;
    assign w_overlap = 1'b1;
`endif

    assign w_same = (w_ram1 && w_ram2 && (w_idx1 == w_idx2)) ||
                    (w_ctl1 && w_ctl2 && (w_cidx1 == w_cidx2));
    assign w_coll = w_ready && bus.enw1 && bus.enw2 && w_same && w_overlap;

    assign w_wr_ram1 = w_ready && bus.enw1 && w_ram1;
    assign w_wr_ctl1 = w_ready && bus.enw1 && w_ctl1;
    assign w_wr_ram2 = w_ready && bus.enw2 && w_ram2 && !w_coll;
    assign w_wr_ctl2 = w_ready && bus.enw2 && w_ctl2 && !w_coll;

    // Both ports landing on one RAM word without collision: port 1 writes the merged word.
    assign w_merge   = w_wr_ram1 && w_wr_ram2 && (w_idx1 == w_idx2);
    assign w_mem_p2  = (r_mem[w_idx2] & ~w_mask2) | (bus.wdata2 & w_mask2);
    assign w_p1_base = w_merge ? w_mem_p2 : r_mem[w_idx1];
    assign w_mem_p1  = (w_p1_base & ~w_mask1) | (bus.wdata1 & w_mask1);

    // Port 2 applied first, port 1 on top, so port 1 wins any shared byte.
    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_wr_ctl2)
            w_ctrl_nxt[w_cidx2] = (r_ctrl[w_cidx2] & ~w_mask2) | (bus.wdata2 & w_mask2);
        if (w_wr_ctl1)
            w_ctrl_nxt[w_cidx1] = (w_ctrl_nxt[w_cidx1] & ~w_mask1) | (bus.wdata1 & w_mask1);
    end

    // CLR_REQ is always 0 in IDLE, so a 1 in the next value means this edge wrote it.
    assign w_clr_start = ((w_wr_ctl1 && (w_cidx1 == '0)) || (w_wr_ctl2 && (w_cidx2 == '0))) &&
                         w_ctrl_nxt[0][0];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_clr_start)     w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_cnt == LAST)   w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_ready    = (r_state == ST_IDLE);
        w_clr_busy = (r_state == ST_CLEAR);
        w_clr_last = (r_state == ST_CLEAR) && (r_cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst)              r_cnt <= '0;
        else if (w_clr_start) r_cnt <= '0;
        else if (w_clr_busy)  r_cnt <= r_cnt + CW'(1);
    end

    // RAM array has no reset; a reset edge blocks the write so a mid-clear abort stops cleanly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_busy) begin
                r_mem[r_cnt] <= '0;
            end else begin
                if (w_wr_ram2 && !w_merge) r_mem[w_idx2] <= w_mem_p2;
                if (w_wr_ram1)             r_mem[w_idx1] <= w_mem_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCTRL; k++) r_ctrl[k] <= '0;
        end else if (w_ready) begin
            r_ctrl <= w_ctrl_nxt;
        end else if (w_clr_last) begin
            r_ctrl[0][0] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata1   <= '0;
            r_rdata2   <= '0;
            r_coll     <= 1'b0;
            r_done     <= 1'b0;
            r_unmapped <= 2'b00;
        end else begin
            if (w_ready && bus.enr1)
                r_rdata1 <= w_ram1 ? r_mem[w_idx1] : (w_ctl1 ? r_ctrl[w_cidx1] : '0);
            if (w_ready && bus.enr2)
                r_rdata2 <= w_ram2 ? r_mem[w_idx2] : (w_ctl2 ? r_ctrl[w_cidx2] : '0);
            r_coll        <= w_coll;
            r_done        <= w_clr_last;
            r_unmapped[0] <= w_ready && (bus.enr1 || bus.enw1) && !w_ram1 && !w_ctl1;
            r_unmapped[1] <= w_ready && (bus.enr2 || bus.enw2) && !w_ram2 && !w_ctl2;
        end
    end

    assign bus.rdata1     = r_rdata1;
    assign bus.rdata2     = r_rdata2;
    assign bus.ready      = w_ready;
    assign bus.coll       = r_coll;
    assign bus.unmapped   = r_unmapped;
    assign bus.clear_done = r_done;

    for (genvar k = 0; k < NCTRL; k++) begin : g_ctrl_out
        assign bus.ctrl_out[k*WIDTH +: WIDTH] = r_ctrl[k];
    end
endmodule

// File: tb/tb_dualram_ctrl.sv
module tb_dualram_ctrl;
    localparam int W     = 32;
    localparam int DEPTH = 1200;
    localparam int BASE  = 206800;
    localparam int CA    = 411698;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dualram_ctrl_if #(.WIDTH(W), .NCTRL(2)) bus ();
    dualram_ctrl #(.WIDTH(W), .DEPTH(DEPTH), .BASE(BASE), .CTRL_ADDR(CA), .NCTRL(2))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    int n_coll, n_unm1, n_unm2, n_done;
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.enw1 = 1'b0; bus.enw2 = 1'b0; bus.enr1 = 1'b0; bus.enr2 = 1'b0;
        bus.address1 = '0; bus.address2 = '0; bus.wdata1 = '0; bus.wdata2 = '0;
`ifdef DUALRAM_BYTEWR_EN
        bus.wstrb1 = '1; bus.wstrb2 = '1;
`endif
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d);
        if (p == 1) begin bus.enw1 = 1'b1; bus.address1 = a; bus.wdata1 = d; end
        else        begin bus.enw2 = 1'b1; bus.address2 = a; bus.wdata2 = d; end
    endtask

    task automatic rd(input int p, input logic [31:0] a, input logic [31:0] e);
        if (p == 1) begin bus.enr1 = 1'b1; bus.address1 = a; q1.push_back(e); end
        else        begin bus.enr2 = 1'b1; bus.address2 = a; q2.push_back(e); end
    endtask

    // One clock: accepted reads pop their expectation and are compared just after the edge.
    task automatic tick();
        logic rd1, rd2;
        logic [31:0] e;
        rd1 = bus.enr1 && bus.ready && !rst;
        rd2 = bus.enr2 && bus.ready && !rst;
        @(posedge clk);
        #1;
        if (rd1) begin e = q1.pop_front(); chk("rdata1", 64'(bus.rdata1), 64'(e)); end
        if (rd2) begin e = q2.pop_front(); chk("rdata2", 64'(bus.rdata2), 64'(e)); end
        if (bus.coll)        n_coll++;
        if (bus.unmapped[0]) n_unm1++;
        if (bus.unmapped[1]) n_unm2++;
        if (bus.clear_done)  n_done++;
    endtask

    task automatic zero_counts();
        n_coll = 0; n_unm1 = 0; n_unm2 = 0; n_done = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        idle();
        zero_counts();
        rst = 1'b1;
        tick(); tick();
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_rdata1", 64'(bus.rdata1), 64'd0);
        chk("rst_rdata2", 64'(bus.rdata2), 64'd0);
        chk("rst_ctrl", 64'(bus.ctrl_out), 64'd0);
        chk("rst_pulses", 64'({bus.coll, bus.unmapped, bus.clear_done}), 64'd0);
        rst = 1'b0;
        zero_counts();

        // write then read on the other port
        wr(1, BASE, 32'hDEADBEEF); tick(); idle();
        rd(2, BASE, 32'hDEADBEEF); tick(); idle();

        // same-address collision: port 1 wins
        wr(1, 207000, 32'h11); wr(2, 207000, 32'h22); tick(); idle();
        chk("coll_pulse", 64'(bus.coll), 64'd1);
        tick();
        chk("coll_clear", 64'(bus.coll), 64'd0);
        rd(1, 207000, 32'h11); tick(); idle();
        chk("coll_count", 64'(n_coll), 64'd1);

        // read-during-write returns old data
        wr(1, 207001, 32'h66); tick(); idle();
        wr(1, 207001, 32'h77); rd(2, 207001, 32'h66); tick(); idle();
        rd(2, 207001, 32'h77); tick(); idle();

        // unmapped reads on port 2 either side of the RAM window
        rd(2, BASE - 1, 32'h0); tick(); idle();
        rd(2, 208000, 32'h0); tick(); idle();
        tick();
        chk("unm2_count", 64'(n_unm2), 64'd2);
        chk("unm1_quiet", 64'(n_unm1), 64'd0);
        wr(1, 208000, 32'h99); tick(); idle();
        chk("unm_wr", 64'(bus.unmapped), 64'b01);
        rd(1, BASE, 32'hDEADBEEF); tick(); idle();

        // top RAM word and control register window
        wr(2, BASE + DEPTH - 1, 32'h0BADF00D); tick(); idle();
        rd(1, BASE + DEPTH - 1, 32'h0BADF00D); tick(); idle();
        wr(2, CA + 1, 32'h1234); tick(); idle();
        rd(1, CA + 1, 32'h1234); tick(); idle();
        chk("ctrl1", 64'(bus.ctrl_out[63:32]), 64'h1234);
        rd(1, CA + 2, 32'h0); tick(); idle();
        chk("unm_ctrl_end", 64'(bus.unmapped), 64'b01);
        wr(1, CA, 32'h4); tick(); idle();
        chk("no_clr_on_0", 64'(bus.ready), 64'd1);

        // full clear
        wr(1, BASE + 500, 32'hCAFE0500); wr(2, BASE + 5, 32'h55); tick(); idle();
        wr(1, CA, 32'h5); tick(); idle();
        zero_counts();
        bus.enr2 = 1'b1; bus.address2 = BASE - 1;
        cnt = 0;
        while (bus.ready == 1'b0 && cnt < 2000) begin
            cnt++;
            if (cnt == 100) idle();
            tick();
        end
        idle();
        chk("clr_cycles", 64'(cnt), 64'd1200);
        chk("clr_done_now", 64'(bus.clear_done), 64'd1);
        chk("clr_unm", 64'(n_unm1 + n_unm2), 64'd0);
        chk("clr_ctrl0", 64'(bus.ctrl_out[31:0]), 64'h4);
        chk("clr_ctrl1", 64'(bus.ctrl_out[63:32]), 64'h1234);
        tick();
        chk("clr_done_once", 64'(n_done), 64'd1);
        chk("clr_done_off", 64'(bus.clear_done), 64'd0);
        for (int i = 0; i < DEPTH / 2; i++) begin
            rd(1, BASE + 2 * i, 32'h0);
            rd(2, BASE + 2 * i + 1, 32'h0);
            tick();
        end
        idle();

        // reset in the middle of a clear
        wr(1, BASE + 5, 32'h55); wr(2, BASE + 500, 32'hCAFE0500); tick(); idle();
        wr(1, CA, 32'h1); tick(); idle();
        chk("clr2_busy", 64'(bus.ready), 64'd0);
        zero_counts();
        repeat (10) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_ready", 64'(bus.ready), 64'd1);
        chk("abort_ctrl", 64'(bus.ctrl_out), 64'd0);
        chk("abort_done", 64'(n_done), 64'd0);
        rd(1, BASE + 5, 32'h0); rd(2, BASE + 500, 32'hCAFE0500); tick(); idle();

`ifdef DUALRAM_BYTEWR_EN
        wr(1, BASE + 20, 32'hAABBCCDD); tick(); idle();
        wr(1, BASE + 20, 32'h11223344); bus.wstrb1 = 4'b0101; tick(); idle();
        rd(2, BASE + 20, 32'hAA22CC44); tick(); idle();
        zero_counts();
        wr(1, BASE + 20, 32'h000000EE); bus.wstrb1 = 4'b0001;
        wr(2, BASE + 20, 32'hFF000000); bus.wstrb2 = 4'b1000;
        tick(); idle(); tick();
        chk("strb_nocoll", 64'(n_coll), 64'd0);
        rd(1, BASE + 20, 32'hFF22CCEE); tick(); idle();
`endif

        chk("q_drained", 64'(q1.size() + q2.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
